// File: rtl/ex_mem_elastic_stage_pkg.sv
// Shared definitions for elastic pipeline stages.
// State encoding, reset PC and control-field bit positions.
package ex_mem_elastic_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  localparam int CTRL_REG_WRITE    = 0;
  localparam int CTRL_MEM_WRITE    = 1;
  localparam int CTRL_HI_WRITE     = 2;
  localparam int CTRL_LO_WRITE     = 3;
  localparam int CTRL_MEM_CTRL_LSB = 4;
  localparam int CTRL_MEM_CTRL_W   = 4;

endpackage

// File: rtl/ex_mem_elastic_stage_sat_counter.sv
// Saturating event counter, cleared only by reset.
// Shared by every elastic stage for stall accounting.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next value: step by one, hold at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/ex_mem_elastic_stage.sv
// Elastic EX/MEM stage: valid/ready register slice
// with optional 2-entry skid buffer, flush and stall counter.
module ex_mem_elastic_stage
  import ex_mem_elastic_stage_pkg::*;
#(
  parameter int              CTRL_W   = 16,
  parameter int              DATA_W   = 96,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] PC_RESET = PC_W'(RESET_PC),
  parameter int              SKID     = 1,
  parameter int              CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              valid_w;
  logic              ready_w;
  logic              in_fire;
  logic              out_fire;
  logic [CTRL_W-1:0] main_ctrl_w;
  logic [DATA_W-1:0] main_data_w;
  logic [PC_W-1:0]   main_pc_w;

  assign in_fire  = in_valid & ready_w;
  assign out_fire = valid_w & out_ready;

  if (SKID != 0) begin : g_skid

    stage_state_e      state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [PC_W-1:0]   main_pc_q, main_pc_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;

    // Occupancy FSM and entry movement; flush wins.
    always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      main_pc_d   = main_pc_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      skid_pc_d   = skid_pc_q;
      if (flush) begin
        state_d     = ST_EMPTY;
        main_ctrl_d = '0;
        main_pc_d   = PC_RESET;
        skid_ctrl_d = '0;
        skid_pc_d   = PC_RESET;
      end else begin
        unique case (state_q)
          ST_EMPTY: begin
            if (in_fire) begin
              state_d     = ST_ONE;
              main_ctrl_d = in_ctrl;
              main_data_d = in_data;
              main_pc_d   = in_pc;
            end
          end
          ST_ONE: begin
            if (in_fire && out_fire) begin
              main_ctrl_d = in_ctrl;
              main_data_d = in_data;
              main_pc_d   = in_pc;
            end else if (in_fire) begin
              state_d     = ST_TWO;
              skid_ctrl_d = in_ctrl;
              skid_data_d = in_data;
              skid_pc_d   = in_pc;
            end else if (out_fire) begin
              state_d = ST_EMPTY;
            end
          end
          ST_TWO: begin
            if (out_fire) begin
              state_d     = ST_ONE;
              main_ctrl_d = skid_ctrl_q;
              main_data_d = skid_data_q;
              main_pc_d   = skid_pc_q;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end
    end

    // State and entry registers.
    always_ff @(posedge clock) begin
      if (!reset) begin
        state_q     <= ST_EMPTY;
        main_ctrl_q <= '0;
        main_data_q <= '0;
        main_pc_q   <= PC_RESET;
        skid_ctrl_q <= '0;
        skid_data_q <= '0;
        skid_pc_q   <= '0;
      end else begin
        state_q     <= state_d;
        main_ctrl_q <= main_ctrl_d;
        main_data_q <= main_data_d;
        main_pc_q   <= main_pc_d;
        skid_ctrl_q <= skid_ctrl_d;
        skid_data_q <= skid_data_d;
        skid_pc_q   <= skid_pc_d;
      end
    end

    assign valid_w     = (state_q != ST_EMPTY);
    assign ready_w     = (state_q != ST_TWO);
    assign main_ctrl_w = main_ctrl_q;
    assign main_data_w = main_data_q;
    assign main_pc_w   = main_pc_q;

  end else begin : g_single

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [PC_W-1:0]   main_pc_q, main_pc_d;

    // Single-entry load/drain; flush wins.
    always_comb begin
      valid_d     = valid_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      main_pc_d   = main_pc_q;
      if (flush) begin
        valid_d     = 1'b0;
        main_ctrl_d = '0;
        main_pc_d   = PC_RESET;
      end else if (in_fire) begin
        valid_d     = 1'b1;
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
        main_pc_d   = in_pc;
      end else if (out_fire) begin
        valid_d = 1'b0;
      end
    end

    // Entry register.
    always_ff @(posedge clock) begin
      if (!reset) begin
        valid_q     <= 1'b0;
        main_ctrl_q <= '0;
        main_data_q <= '0;
        main_pc_q   <= PC_RESET;
      end else begin
        valid_q     <= valid_d;
        main_ctrl_q <= main_ctrl_d;
        main_data_q <= main_data_d;
        main_pc_q   <= main_pc_d;
      end
    end

    assign valid_w     = valid_q;
    assign ready_w     = ~valid_q | out_ready;
    assign main_ctrl_w = main_ctrl_q;
    assign main_data_w = main_data_q;
    assign main_pc_w   = main_pc_q;

  end

  assign in_ready  = ready_w;
  assign out_valid = valid_w;
  assign out_ctrl  = valid_w ? main_ctrl_w : '0;
  assign out_data  = main_data_w;
  assign out_pc    = main_pc_w;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (valid_w & ~out_ready),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_ex_mem_elastic_stage.sv
// Scoreboard bench for ex_mem_elastic_stage.
// Covers SKID=1 (16-bit counter) and SKID=0 (4-bit counter).
module tb_ex_mem_elastic_stage;

  typedef struct packed {
    logic [15:0] ctrl;
    logic [95:0] data;
    logic [31:0] pc;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  item_t q1[$];
  item_t q0[$];
  item_t e1, e0;

  // SKID=1 instance signals
  logic        r1, iv1, ir1, fl1, ov1, or1;
  logic [15:0] ic1, oc1;
  logic [95:0] id1, od1;
  logic [31:0] ip1, op1;
  logic [15:0] sc1;

  // SKID=0 instance signals
  logic        r0, iv0, ir0, fl0, ov0, or0;
  logic [15:0] ic0, oc0;
  logic [95:0] id0, od0;
  logic [31:0] ip0, op0;
  logic [3:0]  sc0;

  ex_mem_elastic_stage #(
    .SKID (1),
    .CNT_W(16)
  ) dut1 (
    .clock    (clk),
    .reset    (r1),
    .in_valid (iv1),
    .in_ready (ir1),
    .in_ctrl  (ic1),
    .in_data  (id1),
    .in_pc    (ip1),
    .flush    (fl1),
    .out_valid(ov1),
    .out_ready(or1),
    .out_ctrl (oc1),
    .out_data (od1),
    .out_pc   (op1),
    .stall_cnt(sc1)
  );

  ex_mem_elastic_stage #(
    .SKID (0),
    .CNT_W(4)
  ) dut0 (
    .clock    (clk),
    .reset    (r0),
    .in_valid (iv0),
    .in_ready (ir0),
    .in_ctrl  (ic0),
    .in_data  (id0),
    .in_pc    (ip0),
    .flush    (fl0),
    .out_valid(ov0),
    .out_ready(or0),
    .out_ctrl (oc0),
    .out_data (od0),
    .out_pc   (op0),
    .stall_cnt(sc0)
  );

  function automatic item_t mk(input logic [31:0] pc);
    item_t it;
    it.pc   = pc;
    it.ctrl = pc[15:0] ^ 16'h5a0f;
    it.data = {pc, ~pc, pc ^ 32'h1234_5678};
    return it;
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic v, input item_t it,
                      input logic push);
    iv1 = v;
    ic1 = it.ctrl;
    id1 = it.data;
    ip1 = it.pc;
    if (push) q1.push_back(it);
  endtask

  task automatic drv0(input logic v, input item_t it,
                      input logic push);
    iv0 = v;
    ic0 = it.ctrl;
    id0 = it.data;
    ip0 = it.pc;
    if (push) q0.push_back(it);
  endtask

  // Monitor for the SKID=1 instance
  always @(negedge clk) begin
    if (r1 && ov1 && or1) begin
      if (q1.size() == 0) begin
        n_chk++;
        $display("FAIL mon1_unexpected: got pc %0h required none", op1);
      end else begin
        e1 = q1.pop_front();
        chk("mon1_pc", 128'(op1), 128'(e1.pc));
        chk("mon1_ctrl", 128'(oc1), 128'(e1.ctrl));
        chk("mon1_data", 128'(od1), 128'(e1.data));
      end
    end
  end

  // Monitor for the SKID=0 instance
  always @(negedge clk) begin
    if (r0 && ov0 && or0) begin
      if (q0.size() == 0) begin
        n_chk++;
        $display("FAIL mon0_unexpected: got pc %0h required none", op0);
      end else begin
        e0 = q0.pop_front();
        chk("mon0_pc", 128'(op0), 128'(e0.pc));
        chk("mon0_ctrl", 128'(oc0), 128'(e0.ctrl));
        chk("mon0_data", 128'(od0), 128'(e0.data));
      end
    end
  end

  initial begin
    r1 = 1'b0; fl1 = 1'b0; or1 = 1'b0;
    r0 = 1'b0; fl0 = 1'b0; or0 = 1'b0;
    drv1(1'b1, mk(32'hdead0000), 1'b0);
    drv0(1'b1, mk(32'hdead0004), 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst1_out_valid", 128'(ov1), 128'(0));
    chk("rst1_out_ctrl", 128'(oc1), 128'(0));
    chk("rst1_out_data", 128'(od1), 128'(0));
    chk("rst1_out_pc", 128'(op1), 128'(32'hbfc00000));
    chk("rst1_in_ready", 128'(ir1), 128'(1));
    chk("rst1_stall", 128'(sc1), 128'(0));
    chk("rst0_out_valid", 128'(ov0), 128'(0));
    chk("rst0_out_pc", 128'(op0), 128'(32'hbfc00000));
    chk("rst0_in_ready", 128'(ir0), 128'(1));
    chk("rst0_stall", 128'(sc0), 128'(0));

    // Streaming, one per cycle, SKID=1
    cyc();
    r1 = 1'b1; r0 = 1'b1; or1 = 1'b1;
    drv0(1'b0, mk(32'h0), 1'b0);
    drv1(1'b1, mk(32'h100), 1'b1);
    @(negedge clk);
    chk("st_in_ready", 128'(ir1), 128'(1));
    chk("st_idle_valid", 128'(ov1), 128'(0));
    cyc();
    drv1(1'b1, mk(32'h104), 1'b1);
    @(negedge clk);
    chk("st_pc0", 128'(op1), 128'(32'h100));
    chk("st_valid0", 128'(ov1), 128'(1));
    cyc();
    drv1(1'b1, mk(32'h108), 1'b1);
    @(negedge clk);
    chk("st_pc1", 128'(op1), 128'(32'h104));
    cyc();
    drv1(1'b0, mk(32'h0), 1'b0);
    @(negedge clk);
    chk("st_pc2", 128'(op1), 128'(32'h108));
    cyc();
    @(negedge clk);
    chk("st_drained", 128'(ov1), 128'(0));
    chk("st_ctrl_gate", 128'(oc1), 128'(0));

    // Backpressure into the skid entry
    cyc();
    or1 = 1'b0;
    drv1(1'b1, mk(32'h200), 1'b1);
    @(negedge clk);
    chk("bp_in_ready0", 128'(ir1), 128'(1));
    cyc();
    drv1(1'b1, mk(32'h204), 1'b1);
    @(negedge clk);
    chk("bp_pc_a", 128'(op1), 128'(32'h200));
    chk("bp_in_ready1", 128'(ir1), 128'(1));
    cyc();
    drv1(1'b0, mk(32'h0), 1'b0);
    @(negedge clk);
    chk("bp_full_ready", 128'(ir1), 128'(0));
    chk("bp_hold_pc", 128'(op1), 128'(32'h200));
    chk("bp_stall1", 128'(sc1), 128'(1));
    repeat (4) cyc();
    @(negedge clk);
    chk("bp_stall5", 128'(sc1), 128'(5));
    chk("bp_hold_pc2", 128'(op1), 128'(32'h200));
    cyc();
    or1 = 1'b1;
    @(negedge clk);
    chk("bp_deliver_a", 128'(op1), 128'(32'h200));
    cyc();
    @(negedge clk);
    chk("bp_deliver_b", 128'(op1), 128'(32'h204));
    chk("bp_ready_back", 128'(ir1), 128'(1));
    cyc();
    @(negedge clk);
    chk("bp_empty", 128'(ov1), 128'(0));
    chk("bp_stall6", 128'(sc1), 128'(6));

    // Flush while TWO with a new input offered
    cyc();
    or1 = 1'b0;
    drv1(1'b1, mk(32'h210), 1'b1);
    cyc();
    drv1(1'b1, mk(32'h214), 1'b1);
    @(negedge clk);
    chk("fl_ready_one", 128'(ir1), 128'(1));
    cyc();
    drv1(1'b1, mk(32'h300), 1'b0);
    fl1 = 1'b1;
    q1.delete();
    @(negedge clk);
    chk("fl_in_two", 128'(ir1), 128'(0));
    cyc();
    fl1 = 1'b0;
    or1 = 1'b1;
    drv1(1'b0, mk(32'h0), 1'b0);
    @(negedge clk);
    chk("fl_valid", 128'(ov1), 128'(0));
    chk("fl_ctrl", 128'(oc1), 128'(0));
    chk("fl_pc", 128'(op1), 128'(32'hbfc00000));
    chk("fl_ready", 128'(ir1), 128'(1));
    chk("fl_stall_kept", 128'(sc1), 128'(8));
    repeat (2) cyc();
    @(negedge clk);
    chk("fl_no_300", 128'(ov1), 128'(0));

    // SKID=0: combinational ready and 4-bit saturation
    cyc();
    or0 = 1'b0;
    drv0(1'b1, mk(32'h400), 1'b1);
    @(negedge clk);
    chk("s0_ready_empty", 128'(ir0), 128'(1));
    cyc();
    drv0(1'b1, mk(32'h404), 1'b1);
    @(negedge clk);
    chk("s0_valid", 128'(ov0), 128'(1));
    chk("s0_pc_a", 128'(op0), 128'(32'h400));
    chk("s0_ready_full", 128'(ir0), 128'(0));
    repeat (20) cyc();
    @(negedge clk);
    chk("s0_sat", 128'(sc0), 128'(15));
    chk("s0_hold_pc", 128'(op0), 128'(32'h400));
    cyc();
    or0 = 1'b1;
    @(negedge clk);
    chk("s0_ready_comb", 128'(ir0), 128'(1));
    cyc();
    drv0(1'b0, mk(32'h0), 1'b0);
    @(negedge clk);
    chk("s0_no_bubble_v", 128'(ov0), 128'(1));
    chk("s0_no_bubble_pc", 128'(op0), 128'(32'h404));
    cyc();
    @(negedge clk);
    chk("s0_empty", 128'(ov0), 128'(0));
    chk("s0_ctrl_gate", 128'(oc0), 128'(0));
    chk("s0_sat_hold", 128'(sc0), 128'(15));

    chk("q1_drained", 128'(q1.size()), 128'(0));
    chk("q0_drained", 128'(q0.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
